// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: matches the last LEN accepted bits against a masked pattern.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_pattern_detector #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic             w,
  input  logic [LEN-1:0]   pattern,
  input  logic [LEN-1:0]   care_mask,
  input  logic             overlap,
  input  logic             clear,
  output logic             z
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
`endif
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] EMPTY = '0;
  localparam logic [FW-1:0] ARMED = FW'(LEN);

  logic [LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d, fill_inc;
  logic           z_q, z_d;
  logic           match;

  always_comb begin
    hist_d   = {hist_q[LEN-2:0], w};
    fill_inc = (fill_q == ARMED) ? ARMED : fill_q + 1'b1;
    match    = w_valid && (fill_inc == ARMED) &&
               (((hist_d ^ pattern) & care_mask) == '0);
    // Non-overlapping mode restarts the fill so the next match needs LEN fresh bits.
    fill_d   = (match && !overlap) ? EMPTY : fill_inc;
    z_d      = match;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      fill_q <= EMPTY;
      z_q    <= 1'b0;
    end else begin
      z_q <= z_d;
      if (w_valid) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end
  end

  assign z = z_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt_q <= '0;
    else if (match && !(&cnt_q))
      cnt_q <= cnt_q + 1'b1;
  end

  assign match_count = cnt_q;
  assign count_sat   = &cnt_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based window model.
module tb_seq_pattern_detector;
  localparam int LEN   = 4;
  localparam int CNT_W = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           w_valid = 1'b0;
  logic           w = 1'b0;
  logic [LEN-1:0] pattern = '0;
  logic [LEN-1:0] care_mask = '0;
  logic           overlap = 1'b0;
  logic           clear = 1'b0;
  logic           z;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
`endif

  seq_pattern_detector #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w(w),
    .pattern(pattern), .care_mask(care_mask), .overlap(overlap), .clear(clear),
    .z(z)
`ifdef SEQDET_COUNT_EN
    , .match_count(match_count), .count_sat(count_sat)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: window of accepted bits, count of bits since last restart, saturating count.
  bit q[$];
  int fresh = 0;
  int exp_cnt = 0;
  bit exp_z = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  always @(posedge clk) begin
    if (reset || clear) begin
      q.delete();
      fresh = 0;
      exp_z = 0;
      exp_cnt = 0;
    end else if (w_valid) begin
      bit m;
      q.push_back(w);
      if (q.size() > LEN) void'(q.pop_front());
      if (fresh < LEN) fresh++;
      m = (fresh == LEN);
      if (m)
        for (int i = 0; i < LEN; i++)
          if (care_mask[i] && (q[q.size()-1-i] != pattern[i])) m = 0;
      exp_z = m;
      if (m) begin
        if (exp_cnt < CMAX) exp_cnt++;
        if (!overlap) fresh = 0;
      end
    end else begin
      exp_z = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("z", {31'd0, z}, {31'd0, exp_z});
`ifdef SEQDET_COUNT_EN
      chk("match_count", 32'(match_count), exp_cnt);
      chk("count_sat", {31'd0, count_sat}, {31'd0, exp_cnt == CMAX});
`endif
    end
  end

  task automatic step(input logic v, input logic b, input logic clr = 1'b0, input logic rst = 1'b0);
    w_valid = v; w = b; clear = clr; reset = rst;
    @(posedge clk); #2;
    w_valid = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  logic [6:0] s7;
  logic [7:0] zs, mzs;

  initial begin
    s7 = 7'b1011011;  // stream 1,1,0,1,1,0,1 sent from bit 0 upward
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    started = 1;
    chk("reset_z", {31'd0, z}, 32'd0);
`ifdef SEQDET_COUNT_EN
    chk("reset_cnt", 32'(match_count), 32'd0);
    chk("reset_sat", {31'd0, count_sat}, 32'd0);
`endif

    // Overlapping match
    pattern = 4'b1101; care_mask = 4'b1111; overlap = 1'b1;
    zs = '0; mzs = '0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s7[i]);
      zs[i] = z; mzs[i] = exp_z;
    end
    chk("ovl_z_seq", 32'(zs), 32'b01001000);
    chk("ovl_model_seq", 32'(mzs), 32'b01001000);
`ifdef SEQDET_COUNT_EN
    chk("ovl_cnt", 32'(match_count), 32'd2);
`endif

    // Non-overlapping match, with an extra trailing 1
    step(1'b0, 1'b0, 1'b1);
    overlap = 1'b0;
    zs = '0; mzs = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 7) ? 1'b1 : s7[i]);
      zs[i] = z; mzs[i] = exp_z;
    end
    chk("novl_z_seq", 32'(zs), 32'b00001000);
    chk("novl_model_seq", 32'(mzs), 32'b00001000);
`ifdef SEQDET_COUNT_EN
    chk("novl_cnt", 32'(match_count), 32'd1);
`endif

    // Don't-care mask with idle gaps
    step(1'b0, 1'b0, 1'b1);
    pattern = 4'b1001; care_mask = 4'b1001;
    zs = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 1) ? 1'b0 : 1'b1);
      zs[2*i] = z;
      step(1'b0, 1'b1);
      zs[2*i+1] = z;
    end
    chk("gap_z_seq", 32'(zs), 32'b01000000);

    // Clear mid-stream, then clear together with an accepted bit
    step(1'b0, 1'b0, 1'b1);
    pattern = 4'b1101; care_mask = 4'b1111; overlap = 1'b1;
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("clear_no_z", {31'd0, z}, 32'd0);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clear_drop_z", {31'd0, z}, 32'd0);

    // Reset on the completing edge
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_drop_z", {31'd0, z}, 32'd0);
`ifdef SEQDET_COUNT_EN
    chk("rst_cnt", 32'(match_count), 32'd0);
    chk("rst_sat", {31'd0, count_sat}, 32'd0);

    // Saturation: with no cared bits every armed accept matches
    care_mask = 4'b0000; overlap = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      chk("sat_cnt", 32'(match_count), (i < 3) ? i + 1 : 3);
      chk("sat_flag", {31'd0, count_sat}, (i >= 2) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0);
    chk("sat_hold", {31'd0, count_sat}, 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_clear", {31'd0, count_sat}, 32'd0);
`endif

    // Randomized traffic; sparse masks keep matches frequent
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) pattern = LEN'($urandom);
      if ($urandom_range(0, 49) == 0) care_mask = LEN'($urandom) & LEN'($urandom);
      if ($urandom_range(0, 29) == 0) overlap = ~overlap;
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'($urandom),
           ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
